// File: rtl/inst_encoder.sv
// inst_encoder: packs RV32I field bundles into instruction words and writes them sequentially into IMEM.
// Optional checking is enabled with `define INST_ENC_CHECK_EN (illegal-format skip and B/JAL alignment error).
module inst_encoder #(
    parameter int ADDR_W = 12,
    parameter int CNT_W  = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  count,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_fmt,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [2:0]        in_funct3,
    input  logic [6:0]        in_funct7,
    input  logic [31:0]       in_imm,
    output logic              imem_wena,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [3:0] F_R     = 4'd0;
    localparam logic [3:0] F_I     = 4'd1;
    localparam logic [3:0] F_IL    = 4'd2;
    localparam logic [3:0] F_S     = 4'd3;
    localparam logic [3:0] F_B     = 4'd4;
    localparam logic [3:0] F_JAL   = 4'd5;
    localparam logic [3:0] F_JALR  = 4'd6;
    localparam logic [3:0] F_LUI   = 4'd7;
    localparam logic [3:0] F_AUIPC = 4'd8;

    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [CNT_W-1:0]  r_remain;
    logic              r_wena_p1;
    logic [ADDR_W-1:0] r_addr_p1;
    logic [31:0]       r_wdata_p1;

    logic              w_hs;
    logic              w_last;
    logic              w_skip;
    logic [31:0]       w_word;

    function automatic logic [31:0] encode_word(
        input logic [3:0]  fmt,
        input logic [4:0]  rd,
        input logic [4:0]  rs1,
        input logic [4:0]  rs2,
        input logic [2:0]  f3,
        input logic [6:0]  f7,
        input logic [31:0] imm
    );
        logic [31:0] word;
        word = NOP_WORD;
        case (fmt)
            F_R:     word = {f7, rs2, rs1, f3, rd, 7'b0110011};
            F_I:     word = {imm[11:0], rs1, f3, rd, 7'b0010011};
            F_IL:    word = {imm[11:0], rs1, f3, rd, 7'b0000011};
            F_S:     word = {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
            F_B:     word = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
            F_JAL:   word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
            F_JALR:  word = {imm[11:0], rs1, f3, rd, 7'b1100111};
            F_LUI:   word = {imm[31:12], rd, 7'b0110111};
            F_AUIPC: word = {imm[31:12], rd, 7'b0010111};
            default: word = NOP_WORD;
        endcase
        return word;
    endfunction

    assign in_ready = (r_state == S_RUN);
    assign busy     = (r_state == S_RUN);
    assign done     = (r_state == S_DONE);
    assign w_hs     = in_valid && (r_state == S_RUN);
    assign w_last   = (r_remain == CNT_W'(1));
    assign w_word   = encode_word(in_fmt, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm);

`ifdef INST_ENC_CHECK_EN
    logic r_err;
    logic w_misalign;

    // Illegal formats are consumed without touching the count or address.
    assign w_skip     = (in_fmt > F_AUIPC);
    assign w_misalign = ((in_fmt == F_B) || (in_fmt == F_JAL)) && in_imm[0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if ((r_state == S_IDLE) && start) begin
            r_err <= 1'b0;
        end else if (w_hs && (w_skip || w_misalign)) begin
            r_err <= 1'b1;
        end
    end

    assign err = r_err;
`else
    assign w_skip = 1'b0;
    assign err    = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_addr     <= '0;
            r_remain   <= '0;
            r_wena_p1  <= 1'b0;
            r_addr_p1  <= '0;
            r_wdata_p1 <= '0;
        end else begin
            r_wena_p1 <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_addr   <= base_addr;
                        r_remain <= count;
                        r_state  <= (count == '0) ? S_DONE : S_RUN;
                    end
                end
                S_RUN: begin
                    // Write stage: the accepted word appears on the IMEM port one cycle later.
                    if (w_hs && !w_skip) begin
                        r_wena_p1  <= 1'b1;
                        r_addr_p1  <= r_addr;
                        r_wdata_p1 <= w_word;
                        r_addr     <= r_addr + ADDR_W'(4);
                        r_remain   <= r_remain - CNT_W'(1);
                        if (w_last) begin
                            r_state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign imem_wena  = r_wena_p1;
    assign imem_addr  = r_addr_p1;
    assign imem_wdata = r_wdata_p1;

endmodule

// File: tb/tb_inst_encoder.sv
// Self-checking bench for inst_encoder: directed RV32I vectors plus randomized loads against a field-level model.
module tb_inst_encoder;

    typedef struct {
        logic [3:0]  fmt;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
    } bundle_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [11:0] base_addr = '0;
    logic [9:0]  count = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  in_fmt = '0;
    logic [4:0]  in_rd = '0;
    logic [4:0]  in_rs1 = '0;
    logic [4:0]  in_rs2 = '0;
    logic [2:0]  in_funct3 = '0;
    logic [6:0]  in_funct7 = '0;
    logic [31:0] in_imm = '0;
    logic        imem_wena;
    logic [11:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        busy;
    logic        done;
    logic        err;

    int n_checks = 0;
    int n_errors = 0;

    bundle_t     bq[$];
    logic [11:0] exp_addr[$];
    logic [31:0] exp_data[$];
    int          exp_cnt;
    logic        exp_err;

    logic [11:0] mon_addr[$];
    logic [31:0] mon_data[$];
    int          mon_cyc[$];
    int          cyc = 0;
    int          done_cnt = 0;
    int          done_cyc = -1;
    int          start_cyc = 0;

    always #5 clk = ~clk;

    inst_encoder #(.ADDR_W(12), .CNT_W(10)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .count(count),
        .in_valid(in_valid), .in_ready(in_ready), .in_fmt(in_fmt), .in_rd(in_rd),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_funct3(in_funct3), .in_funct7(in_funct7),
        .in_imm(in_imm), .imem_wena(imem_wena), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .busy(busy), .done(done), .err(err)
    );

    // Records every IMEM write and the done pulse, tagged with a cycle index.
    always @(posedge clk) begin
        #1;
        cyc++;
        if (imem_wena === 1'b1) begin
            mon_addr.push_back(imem_addr);
            mon_data.push_back(imem_wdata);
            mon_cyc.push_back(cyc);
        end
        if (done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    function automatic logic [31:0] ref_word(bundle_t b);
        logic [31:0] i;
        logic [31:0] rd;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] f3;
        i   = b.imm;
        rd  = 32'(b.rd) << 7;
        rs1 = 32'(b.rs1) << 15;
        rs2 = 32'(b.rs2) << 20;
        f3  = 32'(b.f3) << 12;
        case (b.fmt)
            4'd0: return (32'(b.f7) << 25) | rs2 | rs1 | f3 | rd | 32'h33;
            4'd1: return ((i & 32'hFFF) << 20) | rs1 | f3 | rd | 32'h13;
            4'd2: return ((i & 32'hFFF) << 20) | rs1 | f3 | rd | 32'h03;
            4'd3: return (((i >> 5) & 32'h7F) << 25) | rs2 | rs1 | f3 | ((i & 32'h1F) << 7) | 32'h23;
            4'd4: return (((i >> 12) & 32'h1) << 31) | (((i >> 5) & 32'h3F) << 25) | rs2 | rs1 | f3
                         | (((i >> 1) & 32'hF) << 8) | (((i >> 11) & 32'h1) << 7) | 32'h63;
            4'd5: return (((i >> 20) & 32'h1) << 31) | (((i >> 1) & 32'h3FF) << 21)
                         | (((i >> 11) & 32'h1) << 20) | (((i >> 12) & 32'hFF) << 12) | rd | 32'h6F;
            4'd6: return ((i & 32'hFFF) << 20) | rs1 | f3 | rd | 32'h67;
            4'd7: return (i & 32'hFFFFF000) | rd | 32'h37;
            4'd8: return (i & 32'hFFFFF000) | rd | 32'h17;
            default: return 32'h13;
        endcase
    endfunction

    function automatic bundle_t rand_bundle(input bit legal_only);
        bundle_t b;
        b.fmt = legal_only ? 4'($urandom_range(0, 8)) : 4'($urandom_range(0, 10));
        b.rd  = 5'($urandom);
        b.rs1 = 5'($urandom);
        b.rs2 = 5'($urandom);
        b.f3  = 3'($urandom);
        b.f7  = 7'($urandom);
        b.imm = $urandom;
        return b;
    endfunction

    function automatic bundle_t mk(input int fmt, input int rd, input int rs1, input int rs2,
                                   input int f3, input logic [31:0] imm);
        bundle_t b;
        b.fmt = 4'(fmt); b.rd = 5'(rd); b.rs1 = 5'(rs1); b.rs2 = 5'(rs2);
        b.f3 = 3'(f3); b.f7 = 7'h0; b.imm = imm;
        return b;
    endfunction

    // Model: expected writes, word count and error flag for the bundles in bq.
    task automatic build_expected(input logic [11:0] base);
        logic [11:0] a;
        a = base;
        exp_addr.delete(); exp_data.delete(); exp_cnt = 0; exp_err = 1'b0;
        foreach (bq[i]) begin
`ifdef INST_ENC_CHECK_EN
            if (bq[i].fmt > 4'd8) begin
                exp_err = 1'b1;
                continue;
            end
            if ((bq[i].fmt == 4'd4 || bq[i].fmt == 4'd5) && bq[i].imm[0]) exp_err = 1'b1;
`endif
            exp_addr.push_back(a);
            exp_data.push_back(ref_word(bq[i]));
            exp_cnt++;
            a = a + 12'd4;
        end
    endtask

    task automatic apply_bundle(input bundle_t b);
        in_fmt = b.fmt; in_rd = b.rd; in_rs1 = b.rs1; in_rs2 = b.rs2;
        in_funct3 = b.f3; in_funct7 = b.f7; in_imm = b.imm;
    endtask

    task automatic drive_load(input logic [11:0] base, input logic [9:0] cnt, input bit gaps,
                              output bit tmo);
        int  idx;
        int  guard;
        bit  hs;
        mon_addr.delete(); mon_data.delete(); mon_cyc.delete();
        done_cnt = 0; done_cyc = -1; tmo = 1'b0;
        @(negedge clk);
        start = 1'b1; base_addr = base; count = cnt;
        @(negedge clk);
        start = 1'b0; start_cyc = cyc;
        base_addr = 12'($urandom); count = 10'($urandom);
        idx = 0; guard = 0;
        while (idx < bq.size() && guard < 500) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                in_valid = 1'b0;
                apply_bundle(rand_bundle(1'b0));
            end else begin
                in_valid = 1'b1;
                apply_bundle(bq[idx]);
            end
            hs = in_valid && in_ready;
            @(negedge clk);
            if (hs) idx++;
            guard++;
        end
        in_valid = 1'b0;
        while (done_cnt == 0 && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 500) tmo = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_checks++;
        if ({in_ready, imem_wena, imem_addr, imem_wdata, busy, done, err} !== '0) begin
            n_errors++;
            $display("FAIL reset_outputs: got rdy=%b wena=%b addr=%h data=%h busy=%b done=%b err=%b, expected all 0",
                     in_ready, imem_wena, imem_addr, imem_wdata, busy, done, err);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({in_ready, imem_wena, busy, done, err} !== '0) begin
            n_errors++;
            $display("FAIL idle_after_reset: got rdy=%b wena=%b busy=%b done=%b err=%b, expected all 0",
                     in_ready, imem_wena, busy, done, err);
        end
    endtask

    task automatic test_addi();
        bit tmo;
        bq.delete();
        bq.push_back(mk(1, 1, 0, 0, 0, 32'd5));
        drive_load(12'h100, 10'd1, 1'b0, tmo);
        n_checks++;
        if (tmo || mon_addr.size() != 1) begin
            n_errors++;
            $display("FAIL addi_count: got %0d writes (timeout=%0d), expected 1", mon_addr.size(), tmo);
        end else begin
            n_checks++;
            if ({mon_addr[0], mon_data[0]} !== {12'h100, 32'h00500093}) begin
                n_errors++;
                $display("FAIL addi_word: got %h@%h, expected 00500093@100", mon_data[0], mon_addr[0]);
            end
            n_checks++;
            if (done_cnt != 1 || done_cyc != mon_cyc[0]) begin
                n_errors++;
                $display("FAIL addi_done: got %0d pulses at cycle %0d, expected 1 at cycle %0d",
                         done_cnt, done_cyc, mon_cyc[0]);
            end
        end
        n_checks++;
        if ({busy, done, imem_wena} !== 3'b000) begin
            n_errors++;
            $display("FAIL addi_idle: got busy=%b done=%b wena=%b, expected 000", busy, done, imem_wena);
        end
    endtask

    task automatic test_back_to_back();
        bit tmo;
        bq.delete();
        bq.push_back(mk(3, 0, 1, 2, 2, 32'd8));
        bq.push_back(mk(7, 5, 0, 0, 0, 32'h12345000));
        drive_load(12'h200, 10'd2, 1'b0, tmo);
        n_checks++;
        if (tmo || mon_addr.size() != 2) begin
            n_errors++;
            $display("FAIL b2b_count: got %0d writes (timeout=%0d), expected 2", mon_addr.size(), tmo);
        end else begin
            n_checks++;
            if ({mon_addr[0], mon_data[0], mon_addr[1], mon_data[1]}
                !== {12'h200, 32'h0020A423, 12'h204, 32'h123452B7}) begin
                n_errors++;
                $display("FAIL b2b_words: got %h@%h %h@%h, expected 0020a423@200 123452b7@204",
                         mon_data[0], mon_addr[0], mon_data[1], mon_addr[1]);
            end
            n_checks++;
            if (mon_cyc[1] != mon_cyc[0] + 1 || done_cyc != mon_cyc[1]) begin
                n_errors++;
                $display("FAIL b2b_timing: got writes at %0d,%0d done at %0d, expected consecutive with done on last",
                         mon_cyc[0], mon_cyc[1], done_cyc);
            end
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_errors++;
            $display("FAIL b2b_busy: got %b, expected 0", busy);
        end
    endtask

    task automatic test_stall();
        bit tmo;
        bq.delete();
        bq.push_back(mk(4, 0, 0, 0, 0, 32'hFFFFFFFC));
        bq.push_back(mk(5, 1, 0, 0, 0, 32'd8));
        drive_load(12'h040, 10'd2, 1'b1, tmo);
        n_checks++;
        if (tmo || mon_addr.size() != 2) begin
            n_errors++;
            $display("FAIL stall_count: got %0d writes (timeout=%0d), expected 2", mon_addr.size(), tmo);
        end else begin
            n_checks++;
            if ({mon_addr[0], mon_data[0], mon_addr[1], mon_data[1]}
                !== {12'h040, 32'hFE000EE3, 12'h044, 32'h008000EF}) begin
                n_errors++;
                $display("FAIL stall_words: got %h@%h %h@%h, expected fe000ee3@040 008000ef@044",
                         mon_data[0], mon_addr[0], mon_data[1], mon_addr[1]);
            end
        end
    endtask

    task automatic test_count_zero_and_wrap();
        bit tmo;
        bq.delete();
        drive_load(12'h080, 10'd0, 1'b0, tmo);
        n_checks++;
        if (tmo || mon_addr.size() != 0 || done_cnt != 1 || done_cyc != start_cyc) begin
            n_errors++;
            $display("FAIL count0: got %0d writes, %0d pulses at %0d (timeout=%0d), expected 0 writes, 1 pulse at %0d",
                     mon_addr.size(), done_cnt, done_cyc, tmo, start_cyc);
        end
        bq.delete();
        bq.push_back(rand_bundle(1'b1));
        bq.push_back(rand_bundle(1'b1));
        bq[0].imm[0] = 1'b0;
        bq[1].imm[0] = 1'b0;
        build_expected(12'hFFC);
        drive_load(12'hFFC, 10'd2, 1'b0, tmo);
        n_checks++;
        if (tmo || mon_addr.size() != 2) begin
            n_errors++;
            $display("FAIL wrap_count: got %0d writes (timeout=%0d), expected 2", mon_addr.size(), tmo);
        end else begin
            n_checks++;
            if ({mon_addr[0], mon_addr[1]} !== {12'hFFC, 12'h000}
                || {mon_data[0], mon_data[1]} !== {exp_data[0], exp_data[1]}) begin
                n_errors++;
                $display("FAIL wrap: got %h@%h %h@%h, expected %h@ffc %h@000",
                         mon_data[0], mon_addr[0], mon_data[1], mon_addr[1], exp_data[0], exp_data[1]);
            end
        end
    endtask

    task automatic test_illegal();
        bit tmo;
        bq.delete();
        bq.push_back(mk(12, 3, 4, 5, 1, 32'h0000ABCD));
`ifdef INST_ENC_CHECK_EN
        bq.push_back(mk(1, 1, 0, 0, 0, 32'd5));
`endif
        drive_load(12'h300, 10'd1, 1'b0, tmo);
        n_checks++;
        if (tmo || mon_addr.size() != 1) begin
            n_errors++;
            $display("FAIL illegal_count: got %0d writes (timeout=%0d), expected 1", mon_addr.size(), tmo);
        end else begin
            n_checks++;
`ifdef INST_ENC_CHECK_EN
            if ({mon_addr[0], mon_data[0], err} !== {12'h300, 32'h00500093, 1'b1}) begin
                n_errors++;
                $display("FAIL illegal_skip: got %h@%h err=%b, expected 00500093@300 err=1",
                         mon_data[0], mon_addr[0], err);
            end
`else
            if ({mon_addr[0], mon_data[0], err} !== {12'h300, 32'h00000013, 1'b0}) begin
                n_errors++;
                $display("FAIL illegal_nop: got %h@%h err=%b, expected 00000013@300 err=0",
                         mon_data[0], mon_addr[0], err);
            end
`endif
        end
        @(negedge clk);
        start = 1'b1; count = 10'd0;
        @(negedge clk);
        start = 1'b0;
        n_checks++;
        if ({err, done} !== 2'b01) begin
            n_errors++;
            $display("FAIL err_clear: got err=%b done=%b, expected err=0 done=1", err, done);
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        bit          tmo;
        logic [11:0] base;
        int          n;
        for (int l = 0; l < 5; l++) begin
            base = 12'($urandom_range(0, 1023) * 4);
            n = $urandom_range(1, 8);
            bq.delete();
            for (int i = 0; i < n; i++) bq.push_back(rand_bundle(i == n - 1));
            build_expected(base);
            drive_load(base, 10'(exp_cnt), 1'(l % 2), tmo);
            n_checks++;
            if (tmo || mon_addr.size() != exp_addr.size()) begin
                n_errors++;
                $display("FAIL rand%0d_count: got %0d writes (timeout=%0d), expected %0d",
                         l, mon_addr.size(), tmo, exp_addr.size());
            end else begin
                for (int i = 0; i < exp_addr.size(); i++) begin
                    n_checks++;
                    if ({mon_addr[i], mon_data[i]} !== {exp_addr[i], exp_data[i]}) begin
                        n_errors++;
                        $display("FAIL rand%0d_word%0d: got %h@%h, expected %h@%h",
                                 l, i, mon_data[i], mon_addr[i], exp_data[i], exp_addr[i]);
                    end
                end
                n_checks++;
                if (done_cnt != 1 || done_cyc != mon_cyc[mon_cyc.size() - 1]) begin
                    n_errors++;
                    $display("FAIL rand%0d_done: got %0d pulses at %0d, expected 1 at %0d",
                             l, done_cnt, done_cyc, mon_cyc[mon_cyc.size() - 1]);
                end
            end
            n_checks++;
            if (err !== exp_err) begin
                n_errors++;
                $display("FAIL rand%0d_err: got %b, expected %b", l, err, exp_err);
            end
        end
    endtask

    task automatic test_reset_midrun();
        bit tmo;
        bq.delete();
        for (int i = 0; i < 5; i++) bq.push_back(rand_bundle(1'b1));
        @(negedge clk);
        start = 1'b1; base_addr = 12'h500; count = 10'd5;
        @(negedge clk);
        start = 1'b0;
        in_valid = 1'b1;
        apply_bundle(bq[0]);
        @(negedge clk);
        apply_bundle(bq[1]);
        @(negedge clk);
        n_checks++;
        if ({imem_wena, busy} !== 2'b11) begin
            n_errors++;
            $display("FAIL midrun_active: got wena=%b busy=%b, expected 11", imem_wena, busy);
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({in_ready, imem_wena, imem_addr, imem_wdata, busy, done, err} !== '0) begin
            n_errors++;
            $display("FAIL midrun_reset: got rdy=%b wena=%b addr=%h data=%h busy=%b done=%b err=%b, expected all 0",
                     in_ready, imem_wena, imem_addr, imem_wdata, busy, done, err);
        end
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({in_ready, busy, done} !== 3'b000) begin
            n_errors++;
            $display("FAIL midrun_idle: got rdy=%b busy=%b done=%b, expected 000", in_ready, busy, done);
        end
        bq.delete();
        bq.push_back(mk(1, 1, 0, 0, 0, 32'd5));
        drive_load(12'h6A0, 10'd1, 1'b0, tmo);
        n_checks++;
        if (tmo || mon_addr.size() != 1) begin
            n_errors++;
            $display("FAIL restart_count: got %0d writes (timeout=%0d), expected 1", mon_addr.size(), tmo);
        end else begin
            n_checks++;
            if ({mon_addr[0], mon_data[0]} !== {12'h6A0, 32'h00500093}) begin
                n_errors++;
                $display("FAIL restart_word: got %h@%h, expected 00500093@6a0", mon_data[0], mon_addr[0]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_addi();
        test_back_to_back();
        test_stall();
        test_count_zero_and_wrap();
        test_illegal();
        test_random();
        test_reset_midrun();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
